// File: rtl/blood_ph_pkg.sv
// Shared width and category type for the blood-pH analyzer.
package blood_ph_pkg;

  localparam int PH_WIDTH = 4;

  typedef enum logic [1:0] {
    PH_NORMAL,
    PH_ACID,
    PH_ALKALI,
    PH_INVALID
  } ph_cat_t;

endpackage

// File: rtl/blood_ph_analyzer_ph_classifier.sv
// Combinational mapping of a raw pH code onto its category.
module ph_classifier
  import blood_ph_pkg::*;
#(
  parameter int unsigned NORMAL_LO = 7,
  parameter int unsigned NORMAL_HI = 7,
  parameter int unsigned PH_MAX    = 14
) (
  input  logic [PH_WIDTH-1:0] i_ph,
  output ph_cat_t             o_cat
);

  localparam logic [PH_WIDTH-1:0] LO  = PH_WIDTH'(NORMAL_LO);
  localparam logic [PH_WIDTH-1:0] HI  = PH_WIDTH'(NORMAL_HI);
  localparam logic [PH_WIDTH-1:0] MAX = PH_WIDTH'(PH_MAX);

  // Invalid is tested first so out-of-range codes never alias to alkaline.
  always_comb begin
    o_cat = PH_NORMAL;
    if (i_ph > MAX) begin
      o_cat = PH_INVALID;
    end else if (i_ph < LO) begin
      o_cat = PH_ACID;
    end else if (i_ph > HI) begin
      o_cat = PH_ALKALI;
    end
  end

endmodule

// File: rtl/blood_ph_analyzer.sv
// Blood-pH classifier with persistence filter and registered outputs.
// Optional macro ABN_COUNT_EN adds saturating acid/alkali event counters.
module blood_ph_analyzer
  import blood_ph_pkg::*;
#(
  parameter int unsigned NORMAL_LO = 7,
  parameter int unsigned NORMAL_HI = 7,
  parameter int unsigned PH_MAX    = 14,
  parameter int unsigned PERSIST   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sampleValid,
  input  logic [PH_WIDTH-1:0] bloodPH,
  output logic                abnormalityP,
  output logic                abnormalityQ,
  output logic                invalidPH
`ifdef ABN_COUNT_EN
  ,
  output logic [7:0]          acidCount,
  output logic [7:0]          alkaliCount
`endif
);

  localparam logic [3:0] PERSIST_C = 4'(PERSIST);

  ph_cat_t    w_cat;
  ph_cat_t    r_last, r_last_next;
  logic [3:0] r_cnt, r_cnt_next;
  logic       r_p, r_p_next;
  logic       r_q, r_q_next;
  logic       r_inv, r_inv_next;

  ph_classifier #(
    .NORMAL_LO (NORMAL_LO),
    .NORMAL_HI (NORMAL_HI),
    .PH_MAX    (PH_MAX)
  ) u_classifier (
    .i_ph  (bloodPH),
    .o_cat (w_cat)
  );

  always_comb begin
    r_last_next = r_last;
    r_cnt_next  = r_cnt;
    r_p_next    = r_p;
    r_q_next    = r_q;
    r_inv_next  = 1'b0;
    if (sampleValid) begin
      if (w_cat == PH_INVALID) begin
        r_inv_next = 1'b1;
      end else begin
        if (w_cat == r_last) begin
          r_cnt_next = (r_cnt >= PERSIST_C) ? PERSIST_C : r_cnt + 4'd1;
        end else begin
          r_last_next = w_cat;
          r_cnt_next  = 4'd1;
        end
        // Outputs follow the run only once it is long enough to trust.
        if (r_cnt_next == PERSIST_C) begin
          r_p_next = (w_cat == PH_ACID);
          r_q_next = (w_cat == PH_ALKALI);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= PH_NORMAL;
      r_cnt  <= 4'd0;
      r_p    <= 1'b0;
      r_q    <= 1'b0;
      r_inv  <= 1'b0;
    end else begin
      r_last <= r_last_next;
      r_cnt  <= r_cnt_next;
      r_p    <= r_p_next;
      r_q    <= r_q_next;
      r_inv  <= r_inv_next;
    end
  end

  assign abnormalityP = r_p;
  assign abnormalityQ = r_q;
  assign invalidPH    = r_inv;

`ifdef ABN_COUNT_EN
  logic [7:0] r_acid_cnt;
  logic [7:0] r_alk_cnt;

  // A rise is counted on the same edge the output register goes 0->1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acid_cnt <= 8'd0;
      r_alk_cnt  <= 8'd0;
    end else begin
      if (r_p_next && !r_p && r_acid_cnt != 8'hFF) begin
        r_acid_cnt <= r_acid_cnt + 8'd1;
      end
      if (r_q_next && !r_q && r_alk_cnt != 8'hFF) begin
        r_alk_cnt <= r_alk_cnt + 8'd1;
      end
    end
  end

  assign acidCount   = r_acid_cnt;
  assign alkaliCount = r_alk_cnt;
`endif

endmodule

// File: tb/tb_blood_ph_analyzer.sv
// Randomized self-checking bench for blood_ph_analyzer (PERSIST=1 and PERSIST=3 instances).
module tb_blood_ph_analyzer;

  localparam int LO   = 7;
  localparam int HI   = 7;
  localparam int PMAX = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sampleValid = 1'b0;
  logic [3:0] bloodPH = 4'd0;

  logic p1, q1, i1, p3, q3, i3;
`ifdef ABN_COUNT_EN
  logic [7:0] acid1, alk1, acid3, alk3;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: accepted non-invalid categories since reset (0 normal, 1 acid, 2 alkali).
  int hist[$];
  bit m_inv = 1'b0;
`ifdef ABN_COUNT_EN
  int m_acid1 = 0, m_alk1 = 0, m_acid3 = 0, m_alk3 = 0;
  int prev1 = 0, prev3 = 0;
`endif

  always #5 clk = ~clk;

  blood_ph_analyzer #(.NORMAL_LO(7), .NORMAL_HI(7), .PH_MAX(14), .PERSIST(1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .sampleValid  (sampleValid),
    .bloodPH      (bloodPH),
    .abnormalityP (p1),
    .abnormalityQ (q1),
    .invalidPH    (i1)
`ifdef ABN_COUNT_EN
    ,
    .acidCount    (acid1),
    .alkaliCount  (alk1)
`endif
  );

  blood_ph_analyzer #(.NORMAL_LO(7), .NORMAL_HI(7), .PH_MAX(14), .PERSIST(3)) dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .sampleValid  (sampleValid),
    .bloodPH      (bloodPH),
    .abnormalityP (p3),
    .abnormalityQ (q3),
    .invalidPH    (i3)
`ifdef ABN_COUNT_EN
    ,
    .acidCount    (acid3),
    .alkaliCount  (alk3)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int classify(input int ph);
    if (ph > PMAX) return 3;
    if (ph < LO) return 1;
    if (ph > HI) return 2;
    return 0;
  endfunction

  // Output category = category of the latest sample that ends a run of p equal categories.
  function automatic int exp_cat(input int p);
    for (int i = hist.size() - 1; i >= p - 1; i--) begin
      bit same = 1'b1;
      for (int k = 0; k < p; k++) begin
        if (hist[i - k] != hist[i]) same = 1'b0;
      end
      if (same) return hist[i];
    end
    return 0;
  endfunction

  task automatic step(input logic rstn, input logic v, input logic [3:0] ph);
    int e1, e3;
    rst_n = rstn;
    sampleValid = v;
    bloodPH = ph;
    @(posedge clk);
    #1;
    if (!rstn) begin
      hist.delete();
      m_inv = 1'b0;
    end else if (v) begin
      if (classify(int'(ph)) == 3) begin
        m_inv = 1'b1;
      end else begin
        m_inv = 1'b0;
        hist.push_back(classify(int'(ph)));
      end
    end else begin
      m_inv = 1'b0;
    end
    e1 = exp_cat(1);
    e3 = exp_cat(3);
    $display("[TB] t=%0t rst_n=%0b v=%0b ph=%0d P1=%0b Q1=%0b I1=%0b P3=%0b Q3=%0b I3=%0b",
             $time, rstn, v, ph, p1, q1, i1, p3, q3, i3);
    check_val("p1_P", 32'(p1), 32'(e1 == 1));
    check_val("p1_Q", 32'(q1), 32'(e1 == 2));
    check_val("p1_inv", 32'(i1), 32'(m_inv));
    check_val("p3_P", 32'(p3), 32'(e3 == 1));
    check_val("p3_Q", 32'(q3), 32'(e3 == 2));
    check_val("p3_inv", 32'(i3), 32'(m_inv));
    check_val("pq_excl1", 32'(p1 & q1), 32'd0);
    check_val("pq_excl3", 32'(p3 & q3), 32'd0);
`ifdef ABN_COUNT_EN
    if (!rstn) begin
      m_acid1 = 0; m_alk1 = 0; m_acid3 = 0; m_alk3 = 0;
    end else begin
      if (e1 == 1 && prev1 != 1 && m_acid1 < 255) m_acid1++;
      if (e1 == 2 && prev1 != 2 && m_alk1 < 255) m_alk1++;
      if (e3 == 1 && prev3 != 1 && m_acid3 < 255) m_acid3++;
      if (e3 == 2 && prev3 != 2 && m_alk3 < 255) m_alk3++;
    end
    prev1 = e1;
    prev3 = e3;
    check_val("acid1", 32'(acid1), 32'(m_acid1));
    check_val("alk1", 32'(alk1), 32'(m_alk1));
    check_val("acid3", 32'(acid3), 32'(m_acid3));
    check_val("alk3", 32'(alk3), 32'(m_alk3));
`endif
  endtask

  initial begin
    logic [3:0] last_ph;
    logic [3:0] seq3 [6];

    // Reset held two cycles, then released idle.
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    check_val("rst_P", 32'(p1), 32'd0);
    check_val("rst_Q", 32'(q1), 32'd0);
    check_val("rst_inv", 32'(i1), 32'd0);

    // PERSIST=1 directed: acid, normal, alkali, then invalid while alkaline.
    step(1'b1, 1'b1, 4'd0);
    check_val("dir_acid_P", 32'(p1), 32'd1);
    step(1'b1, 1'b1, 4'd7);
    check_val("dir_norm_P", 32'(p1), 32'd0);
    check_val("dir_norm_Q", 32'(q1), 32'd0);
    step(1'b1, 1'b1, 4'd10);
    check_val("dir_alk_Q", 32'(q1), 32'd1);
    step(1'b1, 1'b1, 4'd15);
    check_val("dir_inv_pulse", 32'(i1), 32'd1);
    check_val("dir_inv_Qhold", 32'(q1), 32'd1);
    step(1'b1, 1'b0, 4'd15);
    check_val("dir_inv_drop", 32'(i1), 32'd0);
    check_val("dir_idle_Qhold", 32'(q1), 32'd1);
    step(1'b1, 1'b1, 4'd14);
    check_val("dir_phmax_Q", 32'(q1), 32'd1);

    // PERSIST=3 run: 3,3,7,3,3,3.
    step(1'b0, 1'b0, 4'd0);
    seq3[0] = 4'd3; seq3[1] = 4'd3; seq3[2] = 4'd7;
    seq3[3] = 4'd3; seq3[4] = 4'd3; seq3[5] = 4'd3;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, seq3[i]);
      check_val("p3_run_P", 32'(p3), 32'(i == 5));
    end

    // Reset wins over a valid acidic sample.
    step(1'b0, 1'b1, 4'd2);
    check_val("rst_over_valid_P1", 32'(p1), 32'd0);
    check_val("rst_over_valid_P3", 32'(p3), 32'd0);

    // Randomized traffic with runs, boundaries and occasional resets.
    last_ph = 4'd7;
    for (int n = 0; n < 600; n++) begin
      logic [3:0] ph;
      logic v;
      logic r;
      if (($urandom % 2) == 0) ph = last_ph;
      else ph = 4'($urandom_range(0, 15));
      last_ph = ph;
      v = ($urandom % 10) < 7;
      r = ($urandom % 64) != 0;
      step(r, v, ph);
    end

`ifdef ABN_COUNT_EN
    step(1'b0, 1'b0, 4'd0);
    for (int n = 0; n < 50; n++) begin
      step(1'b1, 1'b1, 4'd2);
      step(1'b1, 1'b1, 4'd7);
    end
    check_val("cnt_acid_50", 32'(acid1), 32'd50);
    check_val("cnt_alk_0", 32'(alk1), 32'd0);
    for (int n = 0; n < 300; n++) begin
      step(1'b1, 1'b1, 4'd2);
      step(1'b1, 1'b1, 4'd7);
    end
    check_val("cnt_acid_sat", 32'(acid1), 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
